// File: rtl/irq_priority_encoder_if.sv
// Request/present/acknowledge bundle between interrupt sources and the control unit.
// master = consumer/source side, slave = encoder side.
interface irq_priority_encoder_if;
   logic [7:0] req;
   logic [7:0] mask;
   logic       ack;
   logic [2:0] code;
   logic       valid;
   logic [7:0] pending;

   modport master (output req, output mask, output ack,
                   input code, input valid, input pending);
   modport slave  (input req, input mask, input ack,
                   output code, output valid, output pending);
endinterface

// File: rtl/irq_priority_encoder.sv
// Sticky 8-to-3 priority encoder: req -> valid two edges later; code/valid held until ack.
// After each ack valid drops for one GAP cycle before the next arbitration.
module irq_priority_encoder #(
   parameter bit HIGH_FIRST = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst,
   irq_priority_encoder_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PRESENT = 2'd1,
      GAP     = 2'd2
   } state_t;

   state_t     state;
   logic [7:0] pending_q;
   logic [2:0] code_q;
   logic       valid_q;

   logic [7:0] eligible;
   logic [7:0] clr;
   logic [2:0] enc;

   assign eligible = pending_q & ~bus.mask;
   assign clr      = (valid_q && bus.ack) ? (8'b1 << code_q) : 8'b0;

   // Later loop iterations override earlier ones, so the last hit is the winner.
   always_comb begin
      enc = 3'd0;
      for (int i = 0; i < 8; i++) begin
         if (HIGH_FIRST) begin
            if (eligible[i]) enc = 3'(i);
         end else begin
            if (eligible[7 - i]) enc = 3'(7 - i);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         pending_q <= 8'h00;
         code_q    <= 3'd0;
         valid_q   <= 1'b0;
      end else begin
         // A fresh request on the acked line re-arms it.
         pending_q <= (pending_q & ~clr) | bus.req;
         case (state)
            IDLE: begin
               if (|eligible) begin
                  code_q  <= enc;
                  valid_q <= 1'b1;
                  state   <= PRESENT;
               end
            end
            PRESENT: begin
               if (bus.ack) begin
                  valid_q <= 1'b0;
                  state   <= GAP;
               end
            end
            GAP: begin
               state <= IDLE;
            end
            default: begin
               valid_q <= 1'b0;
               state   <= IDLE;
            end
         endcase
      end
   end

   assign bus.code    = code_q;
   assign bus.valid   = valid_q;
   assign bus.pending = pending_q;

endmodule

// File: tb/tb_irq_priority_encoder.sv
// Bench for irq_priority_encoder: one DUT per priority order, shared stimulus.
module tb_irq_priority_encoder;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   irq_priority_encoder_if bus_hi ();
   irq_priority_encoder_if bus_lo ();

   assign bus_lo.req  = bus_hi.req;
   assign bus_lo.mask = bus_hi.mask;
   assign bus_lo.ack  = bus_hi.ack;

   irq_priority_encoder #(.HIGH_FIRST(1'b1)) dut_hi (.clk(clk), .rst(rst), .bus(bus_hi));
   irq_priority_encoder #(.HIGH_FIRST(1'b0)) dut_lo (.clk(clk), .rst(rst), .bus(bus_lo));

   int tests = 0;
   int fails = 0;

   // Reference model, index 0 = HIGH_FIRST=1, index 1 = HIGH_FIRST=0.
   logic [7:0] m_pend  [2];
   logic [2:0] m_code  [2];
   logic       m_valid [2];
   logic       m_hold  [2];

   typedef struct {
      logic [7:0] req;
      logic [7:0] mask;
      logic       ack;
      logic [2:0] code_hi;
      logic [2:0] code_lo;
      logic       valid;
      logic [7:0] pend_hi;
      logic [7:0] pend_lo;
   } vec_t;

   vec_t vt[18];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         if (fails <= 40) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int pick(input logic [7:0] e, input bit hf);
      if (hf) begin
         for (int i = 7; i >= 0; i--) if (e[i]) return i;
      end else begin
         for (int i = 0; i < 8; i++) if (e[i]) return i;
      end
      return 0;
   endfunction

   function automatic void model_reset();
      for (int k = 0; k < 2; k++) begin
         m_pend[k] = 8'h00; m_code[k] = 3'd0; m_valid[k] = 1'b0; m_hold[k] = 1'b0;
      end
   endfunction

   function automatic void model_step(input logic [7:0] r, input logic [7:0] m, input logic a);
      for (int k = 0; k < 2; k++) begin
         logic [7:0] elig;
         logic [7:0] newp;
         elig = m_pend[k] & ~m;
         newp = m_pend[k];
         if (m_valid[k] && a) newp[m_code[k]] = 1'b0;
         newp = newp | r;
         if (m_valid[k]) begin
            if (a) begin
               m_valid[k] = 1'b0;
               m_hold[k]  = 1'b1;
            end
         end else if (m_hold[k]) begin
            m_hold[k] = 1'b0;
         end else if (elig != 8'h00) begin
            m_code[k]  = 3'(pick(elig, k == 0));
            m_valid[k] = 1'b1;
         end
         m_pend[k] = newp;
      end
   endfunction

   // Called at a negedge: drive, advance one edge, then compare both DUTs with the model.
   task automatic step(input logic [7:0] r, input logic [7:0] m, input logic a);
      bus_hi.req  = r;
      bus_hi.mask = m;
      bus_hi.ack  = a;
      model_step(r, m, a);
      @(posedge clk);
      @(negedge clk);
      chk("model_hi_code",  bus_hi.code,    m_code[0]);
      chk("model_hi_valid", bus_hi.valid,   m_valid[0]);
      chk("model_hi_pend",  bus_hi.pending, m_pend[0]);
      chk("model_lo_code",  bus_lo.code,    m_code[1]);
      chk("model_lo_valid", bus_lo.valid,   m_valid[1]);
      chk("model_lo_pend",  bus_lo.pending, m_pend[1]);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, time %0t required below 200000", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int nvalid;
      int seen_code;

      //          req    mask   ack  c_hi c_lo val  p_hi   p_lo
      vt[0]  = '{8'h20, 8'h00, 1'b0, 3'd0, 3'd0, 1'b0, 8'h20, 8'h20};
      vt[1]  = '{8'h00, 8'h00, 1'b0, 3'd5, 3'd5, 1'b1, 8'h20, 8'h20};
      vt[2]  = '{8'h00, 8'h00, 1'b0, 3'd5, 3'd5, 1'b1, 8'h20, 8'h20};
      vt[3]  = '{8'h00, 8'h00, 1'b1, 3'd5, 3'd5, 1'b0, 8'h00, 8'h00};
      vt[4]  = '{8'h81, 8'h00, 1'b0, 3'd5, 3'd5, 1'b0, 8'h81, 8'h81};
      vt[5]  = '{8'h00, 8'h00, 1'b0, 3'd7, 3'd0, 1'b1, 8'h81, 8'h81};
      vt[6]  = '{8'h00, 8'h00, 1'b1, 3'd7, 3'd0, 1'b0, 8'h01, 8'h80};
      vt[7]  = '{8'h00, 8'h00, 1'b0, 3'd7, 3'd0, 1'b0, 8'h01, 8'h80};
      vt[8]  = '{8'h00, 8'h00, 1'b0, 3'd0, 3'd7, 1'b1, 8'h01, 8'h80};
      vt[9]  = '{8'h00, 8'h00, 1'b1, 3'd0, 3'd7, 1'b0, 8'h00, 8'h00};
      vt[10] = '{8'h0C, 8'h00, 1'b0, 3'd0, 3'd7, 1'b0, 8'h0C, 8'h0C};
      vt[11] = '{8'h00, 8'h08, 1'b0, 3'd2, 3'd2, 1'b1, 8'h0C, 8'h0C};
      vt[12] = '{8'h00, 8'h08, 1'b1, 3'd2, 3'd2, 1'b0, 8'h08, 8'h08};
      vt[13] = '{8'h00, 8'h08, 1'b0, 3'd2, 3'd2, 1'b0, 8'h08, 8'h08};
      vt[14] = '{8'h00, 8'h08, 1'b0, 3'd2, 3'd2, 1'b0, 8'h08, 8'h08};
      vt[15] = '{8'h00, 8'h00, 1'b0, 3'd3, 3'd3, 1'b1, 8'h08, 8'h08};
      vt[16] = '{8'h00, 8'h00, 1'b1, 3'd3, 3'd3, 1'b0, 8'h00, 8'h00};
      vt[17] = '{8'h00, 8'h00, 1'b0, 3'd3, 3'd3, 1'b0, 8'h00, 8'h00};

      bus_hi.req  = 8'h00;
      bus_hi.mask = 8'h00;
      bus_hi.ack  = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      chk("rst_pending", bus_hi.pending, 8'h00);
      chk("rst_valid",   bus_hi.valid,   1'b0);
      chk("rst_code",    bus_hi.code,    3'd0);
      rst = 1'b0;

      // Single request, priority order in both directions, masking.
      for (int i = 0; i < 18; i++) begin
         step(vt[i].req, vt[i].mask, vt[i].ack);
         chk($sformatf("vec%0d_hi_code", i),  bus_hi.code,    vt[i].code_hi);
         chk($sformatf("vec%0d_lo_code", i),  bus_lo.code,    vt[i].code_lo);
         chk($sformatf("vec%0d_valid", i),    bus_hi.valid,   vt[i].valid);
         chk($sformatf("vec%0d_hi_pend", i),  bus_hi.pending, vt[i].pend_hi);
         chk($sformatf("vec%0d_lo_pend", i),  bus_lo.pending, vt[i].pend_lo);
      end

      // Asynchronous reset in the middle of a handshake.
      step(8'h12, 8'h00, 1'b0);
      step(8'h00, 8'h00, 1'b0);
      chk("midrst_pre_code",  bus_hi.code,  3'd4);
      chk("midrst_pre_valid", bus_hi.valid, 1'b1);
      #2 rst = 1'b1;
      #1;
      chk("midrst_pending", bus_hi.pending, 8'h00);
      chk("midrst_valid",   bus_hi.valid,   1'b0);
      chk("midrst_code",    bus_hi.code,    3'd0);
      chk("midrst_lo_pend", bus_lo.pending, 8'h00);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      for (int i = 0; i < 3; i++) begin
         step(8'h00, 8'h00, 1'b0);
         chk("postrst_valid", bus_hi.valid, 1'b0);
      end

      // Frozen presentation, then re-request on the acked line.
      step(8'h40, 8'h00, 1'b0);
      step(8'h00, 8'h00, 1'b0);
      chk("hold_code6", bus_hi.code, 3'd6);
      step(8'h0F, 8'h40, 1'b0);
      chk("hold_masked_code",  bus_hi.code,  3'd6);
      chk("hold_masked_valid", bus_hi.valid, 1'b1);
      step(8'h00, 8'h40, 1'b0);
      chk("hold_masked_code2", bus_hi.code, 3'd6);
      step(8'h40, 8'h00, 1'b1);
      chk("rereq_valid", bus_hi.valid, 1'b0);
      chk("rereq_pend6", bus_hi.pending[6], 1'b1);
      step(8'h00, 8'h00, 1'b0);
      chk("rereq_gap_valid", bus_hi.valid, 1'b0);
      step(8'h00, 8'h00, 1'b0);
      chk("rereq_code",  bus_hi.code,  3'd6);
      chk("rereq_valid2", bus_hi.valid, 1'b1);

      // ack held with nothing pending must be inert.
      do_reset();
      for (int i = 0; i < 10; i++) begin
         step(8'h00, 8'h00, 1'b1);
         chk("idle_ack_valid", bus_hi.valid,   1'b0);
         chk("idle_ack_pend",  bus_hi.pending, 8'h00);
      end
      step(8'h02, 8'h00, 1'b1);
      nvalid = 0;
      seen_code = -1;
      for (int i = 0; i < 6; i++) begin
         step(8'h00, 8'h00, 1'b1);
         if (bus_hi.valid === 1'b1) begin
            nvalid++;
            seen_code = int'(bus_hi.code);
         end
      end
      chk("held_ack_presentations", nvalid, 1);
      chk("held_ack_code", seen_code, 1);
      chk("held_ack_pend", bus_hi.pending, 8'h00);

      // Randomized traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         logic [7:0] r;
         logic [7:0] m;
         r = 8'($urandom & $urandom & $urandom);
         m = ($urandom_range(0, 19) == 0) ? 8'hFF : 8'($urandom & $urandom);
         step(r, m, 1'($urandom_range(0, 1)));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
